// File: rtl/uart_frame_deframer.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_deframer
// Description : Locks onto SYNC_BYTE, reassembles 4 payload bytes into a
//               32-bit word, validates the XOR checksum and tracks link health.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_deframer #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned BYTE_TIMEOUT = 200000,
    parameter int unsigned LINK_TIMEOUT = 75000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        timeout,
    output logic        link_up,
    output logic [7:0]  err_cnt
);

    localparam int c_BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int c_LT_W = $clog2(LINK_TIMEOUT + 1);

    localparam logic [c_BT_W-1:0] c_BT_LAST = c_BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [c_BT_W-1:0] c_BT_ONE  = c_BT_W'(1);
    localparam logic [c_LT_W-1:0] c_LT_MAX  = c_LT_W'(LINK_TIMEOUT);
    localparam logic [c_LT_W-1:0] c_LT_LAST = c_LT_W'(LINK_TIMEOUT - 1);
    localparam logic [c_LT_W-1:0] c_LT_ONE  = c_LT_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_DATA = 2'd1;
    localparam logic [1:0] c_ST_CHK  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_idx;
    logic [7:0]        r_acc;
    logic [31:0]       r_word;
    logic [c_BT_W-1:0] r_byte_tmr;
    logic [c_LT_W-1:0] r_link_tmr;
    logic [31:0]       r_data_out;
    logic              r_data_valid;
    logic              r_frame_err;
    logic              r_timeout;
    logic              r_link_up;
    logic [7:0]        r_err_cnt;
    logic              w_good;
    logic              w_bad;
    logic              w_to;
    logic              w_expire;

    assign w_expire = (r_byte_tmr == c_BT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A received byte always beats an expiring byte timer.
    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        w_to        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (rx_valid) begin
                    if (r_idx == 2'd3) begin
                        w_state_nxt = c_ST_CHK;
                    end
                end else if (w_expire) begin
                    w_state_nxt = c_ST_IDLE;
                    w_to        = 1'b1;
                end
            end
            c_ST_CHK: begin
                if (rx_valid) begin
                    w_state_nxt = c_ST_IDLE;
                    if (rx_data == r_acc) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end else if (w_expire) begin
                    w_state_nxt = c_ST_IDLE;
                    w_to        = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= 2'd0;
            r_acc      <= 8'd0;
            r_word     <= 32'd0;
            r_byte_tmr <= '0;
        end else begin
            if (rx_valid || (w_state_nxt == c_ST_IDLE)) begin
                r_byte_tmr <= '0;
            end else begin
                r_byte_tmr <= r_byte_tmr + c_BT_ONE;
            end

            if ((r_state == c_ST_IDLE) && rx_valid && (rx_data == SYNC_BYTE)) begin
                r_idx <= 2'd0;
                r_acc <= 8'd0;
            end else if ((r_state == c_ST_DATA) && rx_valid) begin
                r_idx <= r_idx + 2'd1;
                r_acc <= r_acc ^ rx_data;
                case (r_idx)
                    2'd0:    r_word[31:24] <= rx_data;
                    2'd1:    r_word[23:16] <= rx_data;
                    2'd2:    r_word[15:8]  <= rx_data;
                    default: r_word[7:0]   <= rx_data;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= 32'd0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_timeout    <= 1'b0;
            r_link_up    <= 1'b0;
            r_link_tmr   <= '0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_data_valid <= w_good;
            r_frame_err  <= w_bad;
            r_timeout    <= w_to;
            if (w_good) begin
                r_data_out <= r_word;
            end

            if (w_good) begin
                r_link_tmr <= '0;
                r_link_up  <= 1'b1;
            end else if (r_link_tmr != c_LT_MAX) begin
                r_link_tmr <= r_link_tmr + c_LT_ONE;
                if (r_link_tmr == c_LT_LAST) begin
                    r_link_up <= 1'b0;
                end
            end

            if ((w_bad || w_to) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign timeout    = r_timeout;
    assign link_up    = r_link_up;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_deframer
// Description : Self-checking bench for uart_frame_deframer with a payload
//               scoreboard, a vector table and hand-written timing sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_deframer;

    localparam int unsigned BYTE_TIMEOUT = 100;
    localparam int unsigned LINK_TIMEOUT = 1000;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        timeout;
    logic        link_up;
    logic [7:0]  err_cnt;

    uart_frame_deframer #(
        .SYNC_BYTE    (8'hA5),
        .BYTE_TIMEOUT (BYTE_TIMEOUT),
        .LINK_TIMEOUT (LINK_TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .timeout    (timeout),
        .link_up    (link_up),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              len;
        logic [0:8][7:0] b;
        int              exp_dv;
        int              exp_fe;
        logic [31:0]     exp_word;
        logic [7:0]      exp_err;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] sb [$];
    int          checks   = 0;
    int          failures = 0;
    int          n_dv     = 0;
    int          n_fe     = 0;
    int          n_to     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pulse counting and payload scoreboard, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (data_valid) begin
                n_dv++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: actual=%0h required=none", data_out);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    if (data_out !== e) begin
                        failures++;
                        $display("FAIL sb_payload: actual=%0h required=%0h", data_out, e);
                    end
                end
            end
            if (frame_err) n_fe++;
            if (timeout)   n_to++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; drives bytes back-to-back and returns at a negedge.
    task automatic send_bytes(input logic [0:8][7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            rx_data  = b[i];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [31:0] w, input logic [7:0] chk);
        logic [0:8][7:0] b;
        b = {8'hA5, w, chk, 24'h0};
        send_bytes(b, 6);
    endtask

    initial begin
        int dv0;
        int fe0;
        int to0;
        logic [0:8][7:0] b;

        vecs[0] = '{6, {8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'h27, 24'h0}, 1, 0, 32'h01001234, 8'd0};
        vecs[1] = '{9, {8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'h27}, 1, 0, 32'h01001234, 8'd0};
        vecs[2] = '{6, {8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'h26, 24'h0}, 0, 1, 32'h01001234, 8'd1};
        vecs[3] = '{6, {8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 24'h0}, 1, 0, 32'hAABBCCDD, 8'd1};
        vecs[4] = '{6, {8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 24'h0}, 1, 0, 32'hA5A5A5A5, 8'd1};
        vecs[5] = '{6, {8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08, 24'h0}, 1, 0, 32'h12345678, 8'd1};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        check("reset_data_out", data_out, 32'h0);
        check("reset_pulses", {29'h0, data_valid, frame_err, timeout}, 32'h0);
        check("reset_link_err", {23'h0, link_up, err_cnt}, 32'h0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            dv0 = n_dv;
            fe0 = n_fe;
            if (vecs[i].exp_dv != 0) sb.push_back(vecs[i].exp_word);
            send_bytes(vecs[i].b, vecs[i].len);
            check($sformatf("vec%0d_dv_latency", i), 32'(data_valid), 32'(vecs[i].exp_dv));
            check($sformatf("vec%0d_fe_latency", i), 32'(frame_err), 32'(vecs[i].exp_fe));
            idle(2);
            check($sformatf("vec%0d_dv_count", i), 32'(n_dv - dv0), 32'(vecs[i].exp_dv));
            check($sformatf("vec%0d_fe_count", i), 32'(n_fe - fe0), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp_word);
            check($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_link_up", i), 32'(link_up), 32'd1);
        end

        // Byte timeout: pulse lands exactly BYTE_TIMEOUT cycles after the last byte.
        b = {8'hA5, 8'h01, 56'h0};
        to0 = n_to;
        send_bytes(b, 2);
        idle(BYTE_TIMEOUT - 1);
        check("to_not_early", 32'(timeout), 32'd0);
        idle(1);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_err_cnt", 32'(err_cnt), 32'd2);
        idle(1);
        check("to_one_cycle", 32'(timeout), 32'd0);
        dv0 = n_dv;
        b = {8'h01, 8'h00, 8'h12, 8'h34, 8'h27, 32'h0};
        send_bytes(b, 5);
        idle(2);
        check("to_idle_no_dv", 32'(n_dv - dv0), 32'd0);
        check("to_count", 32'(n_to - to0), 32'd1);

        // Byte arriving on the expiry cycle keeps the frame alive.
        to0 = n_to;
        dv0 = n_dv;
        b = {8'hA5, 8'h01, 56'h0};
        send_bytes(b, 2);
        idle(BYTE_TIMEOUT - 1);
        sb.push_back(32'h01001234);
        b = {8'h00, 8'h12, 8'h34, 8'h27, 40'h0};
        send_bytes(b, 4);
        check("expiry_byte_dv", 32'(data_valid), 32'd1);
        idle(2);
        check("expiry_byte_no_to", 32'(n_to - to0), 32'd0);
        check("expiry_byte_dv_count", 32'(n_dv - dv0), 32'd1);

        // Link loss after LINK_TIMEOUT cycles of silence.
        idle(LINK_TIMEOUT + 10);
        check("link_lost_idle", 32'(link_up), 32'd0);
        sb.push_back(32'hAABBCCDD);
        send_frame(32'hAABBCCDD, 8'h00);
        check("link_regained", 32'(link_up), 32'd1);
        idle(LINK_TIMEOUT - 1);
        check("link_before_expiry", 32'(link_up), 32'd1);
        idle(1);
        check("link_at_expiry", 32'(link_up), 32'd0);

        // Good frame on the expiry cycle keeps link_up high.
        sb.push_back(32'h01001234);
        send_frame(32'h01001234, 8'h27);
        idle(LINK_TIMEOUT - 6);
        sb.push_back(32'h12345678);
        send_frame(32'h12345678, 8'h08);
        check("keepalive_dv", 32'(data_valid), 32'd1);
        check("keepalive_link", 32'(link_up), 32'd1);
        idle(LINK_TIMEOUT / 2);
        check("keepalive_link_later", 32'(link_up), 32'd1);

        // Reset mid-frame discards the partial frame.
        b = {8'hA5, 8'h01, 8'h00, 48'h0};
        send_bytes(b, 3);
        rst = 1'b1;
        idle(2);
        check("midrst_data_out", data_out, 32'h0);
        check("midrst_outputs", {21'h0, data_valid, frame_err, timeout, link_up, err_cnt}, 32'h0);
        rst = 1'b0;
        idle(1);
        dv0 = n_dv;
        sb.push_back(32'h01001234);
        send_frame(32'h01001234, 8'h27);
        idle(2);
        check("midrst_next_frame_dv", 32'(n_dv - dv0), 32'd1);
        check("midrst_next_frame_data", data_out, 32'h01001234);
        check("midrst_next_frame_err", 32'(err_cnt), 32'd0);

        // Error counter saturation.
        fe0 = n_fe;
        for (int i = 0; i < 300; i++) begin
            send_frame(32'h01001234, 8'h26);
            if (i == 253) check("sat_254", 32'(err_cnt), 32'd254);
            if (i == 254) check("sat_255", 32'(err_cnt), 32'd255);
        end
        idle(2);
        check("sat_held", 32'(err_cnt), 32'd255);
        check("sat_fe_count", 32'(n_fe - fe0), 32'd300);
        check("sat_data_kept", data_out, 32'h01001234);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
